// File: rtl/board_ctl.sv
// board_ctl: playfield store and line-clear engine for the falling-piece game.
// Absorbs locked pieces, reports downward collision, clears full rows and
// serves registered row reads to the renderer.
// Optional feature macro: BOARD_SCORE_EN (line-clear scoring into 'score').
module board_ctl #(
  parameter int ROWS   = 22,
  parameter int COLS   = 10,
  parameter int HIDDEN = 2
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            lock_en,
  input  logic [3:0]      sq_1_col,
  input  logic [3:0]      sq_2_col,
  input  logic [3:0]      sq_3_col,
  input  logic [3:0]      sq_4_col,
  input  logic [4:0]      sq_1_row,
  input  logic [4:0]      sq_2_row,
  input  logic [4:0]      sq_3_row,
  input  logic [4:0]      sq_4_row,
  output logic            collision,
  input  logic [4:0]      rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            busy,
  output logic            clear_done,
  output logic [2:0]      lines_last,
  output logic [15:0]     lines_total,
  output logic            game_over,
  output logic [19:0]     score
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [4:0] ROWS_L   = 5'(ROWS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [3:0] COLS_L   = 4'(COLS);
  localparam logic [4:0] HIDDEN_L = 5'(HIDDEN);

  logic [COLS-1:0] grid_r [ROWS];
  logic [1:0]      state_r;
  logic [4:0]      scan_row_r;
  logic            busy_r;
  logic            clear_done_r;
  logic            game_over_r;
  logic [2:0]      lines_last_r;
  logic [15:0]     lines_total_r;
  logic [COLS-1:0] rd_data_r;

  logic [3:0]      sq_col_s [4];
  logic [4:0]      sq_row_s [4];
  logic [3:0]      sq_ok_s;
  logic            hidden_hit_s;
  logic            row_full_s;

  assign sq_col_s[0] = sq_1_col;
  assign sq_col_s[1] = sq_2_col;
  assign sq_col_s[2] = sq_3_col;
  assign sq_col_s[3] = sq_4_col;
  assign sq_row_s[0] = sq_1_row;
  assign sq_row_s[1] = sq_2_row;
  assign sq_row_s[2] = sq_3_row;
  assign sq_row_s[3] = sq_4_row;

  assign row_full_s = &grid_r[scan_row_r];

  // Qualify each piece square as on-board and detect a lock inside the hidden rows.
  always_comb begin
    sq_ok_s      = 4'b0000;
    hidden_hit_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sq_ok_s[i] = (sq_row_s[i] < ROWS_L) && (sq_col_s[i] < COLS_L);
      if (sq_ok_s[i] && (sq_row_s[i] < HIDDEN_L)) begin
        hidden_hit_s = 1'b1;
      end else begin
        hidden_hit_s = hidden_hit_s;
      end
    end
  end

  // Downward collision: a square sits on the floor or on an occupied cell below it.
  always_comb begin
    collision = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!sq_ok_s[i]) begin
        collision = collision;
      end else if (sq_row_s[i] == LAST_ROW) begin
        collision = 1'b1;
      end else if (grid_r[sq_row_s[i] + 5'd1][sq_col_s[i]]) begin
        collision = 1'b1;
      end else begin
        collision = collision;
      end
    end
  end

  // Lock / scan / clear sequencer together with the playfield and line counters.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      scan_row_r    <= 5'd0;
      busy_r        <= 1'b0;
      clear_done_r  <= 1'b0;
      game_over_r   <= 1'b0;
      lines_last_r  <= 3'd0;
      lines_total_r <= 16'd0;
      for (int r = 0; r < ROWS; r++) begin
        grid_r[r] <= '0;
      end
    end else begin
      clear_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (clr) begin
            game_over_r   <= 1'b0;
            lines_last_r  <= 3'd0;
            lines_total_r <= 16'd0;
            for (int r = 0; r < ROWS; r++) begin
              grid_r[r] <= '0;
            end
          end else if (lock_en && !game_over_r) begin
            for (int i = 0; i < 4; i++) begin
              if (sq_ok_s[i]) begin
                grid_r[sq_row_s[i]][sq_col_s[i]] <= 1'b1;
              end
            end
            if (hidden_hit_s) begin
              game_over_r <= 1'b1;
            end
            scan_row_r   <= LAST_ROW;
            lines_last_r <= 3'd0;
            busy_r       <= 1'b1;
            state_r      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // After k clears the top k rows hold shifted-in zeros and cannot be
          // full, so the scan stops at row k. Each cleared row costs one extra
          // re-check cycle, which keeps the sequence at ROWS + k + 1 cycles.
          if (row_full_s) begin
            state_r <= ST_CLEAR;
          end else if (scan_row_r == {2'b00, lines_last_r}) begin
            state_r      <= ST_DONE;
            clear_done_r <= 1'b1;
          end else begin
            scan_row_r <= scan_row_r - 5'd1;
          end
        end
        ST_CLEAR: begin
          grid_r[0] <= '0;
          for (int r = 1; r < ROWS; r++) begin
            if (5'(r) <= scan_row_r) begin
              grid_r[r] <= grid_r[r-1];
            end
          end
          lines_last_r <= lines_last_r + 3'd1;
          if (lines_total_r != 16'hFFFF) begin
            lines_total_r <= lines_total_r + 16'd1;
          end
          state_r <= ST_SCAN;
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Renderer read port: one-cycle latency, rows past the field read as empty.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= '0;
    end else if (rd_row < ROWS_L) begin
      rd_data_r <= grid_r[rd_row];
    end else begin
      rd_data_r <= '0;
    end
  end

`ifdef BOARD_SCORE_EN
  logic [19:0] score_r;
  logic [20:0] score_sum_s;

  function automatic logic [19:0] line_points(input logic [2:0] n);
    case (n)
      3'd1:    line_points = 20'd100;
      3'd2:    line_points = 20'd300;
      3'd3:    line_points = 20'd500;
      3'd4:    line_points = 20'd800;
      default: line_points = 20'd0;
    endcase
  endfunction

  assign score_sum_s = {1'b0, score_r} + {1'b0, line_points(lines_last_r)};

  // Award points for the finished sequence, saturating at the 20-bit maximum.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      score_r <= 20'd0;
    end else if ((state_r == ST_IDLE) && clr) begin
      score_r <= 20'd0;
    end else if (state_r == ST_DONE) begin
      score_r <= score_sum_s[20] ? 20'hFFFFF : score_sum_s[19:0];
    end
  end

  assign score = score_r;
`else
  assign score = 20'd0;
`endif

  assign rd_data     = rd_data_r;
  assign busy        = busy_r;
  assign clear_done  = clear_done_r;
  assign lines_last  = lines_last_r;
  assign lines_total = lines_total_r;
  assign game_over   = game_over_r;

endmodule

// File: tb/tb_board_ctl.sv
// Scoreboard bench for board_ctl: the driver pushes expected responses from a
// row-list reference model, a monitor pops and compares them as the DUT responds.
`timescale 1ns/1ps
module tb_board_ctl;
  localparam int ROWS = 22;
  localparam int COLS = 10;

  logic        pclk = 1'b0, rst_n = 1'b0, clr = 1'b0, lock_en = 1'b0;
  logic [3:0]  sq_1_col = 4'd0, sq_2_col = 4'd0, sq_3_col = 4'd0, sq_4_col = 4'd0;
  logic [4:0]  sq_1_row = 5'd0, sq_2_row = 5'd0, sq_3_row = 5'd0, sq_4_row = 5'd0;
  logic        collision;
  logic [4:0]  rd_row = 5'd0;
  logic [9:0]  rd_data;
  logic        busy, clear_done, game_over;
  logic [2:0]  lines_last;
  logic [15:0] lines_total;
  logic [19:0] score;

  board_ctl dut (
    .pclk(pclk), .rst_n(rst_n), .clr(clr), .lock_en(lock_en),
    .sq_1_col(sq_1_col), .sq_2_col(sq_2_col), .sq_3_col(sq_3_col), .sq_4_col(sq_4_col),
    .sq_1_row(sq_1_row), .sq_2_row(sq_2_row), .sq_3_row(sq_3_row), .sq_4_row(sq_4_row),
    .collision(collision), .rd_row(rd_row), .rd_data(rd_data), .busy(busy),
    .clear_done(clear_done), .lines_last(lines_last), .lines_total(lines_total),
    .game_over(game_over), .score(score)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int last;
    int tot;
    int over;
    int score;
    int busy;
  } lock_exp_t;

  int        total = 0;
  int        bad = 0;
  lock_exp_t lockq[$];
  int        collq[$];
  int        rdq[$];
  logic      coll_req = 1'b0;
  logic      rd_req = 1'b0;
  logic      rd_req_d = 1'b0;

  // reference model state
  logic [9:0] m_grid [ROWS];
  int         m_total, m_score, m_over;
  int         cur_c[4];
  int         cur_r[4];

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int points(int k);
    case (k)
      1: return 100;
      2: return 300;
      3: return 500;
      4: return 800;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++) m_grid[r] = '0;
    m_total = 0;
    m_score = 0;
    m_over  = 0;
  endfunction

  function automatic int model_coll();
    int hit = 0;
    for (int i = 0; i < 4; i++) begin
      if (cur_r[i] < ROWS && cur_c[i] < COLS) begin
        if (cur_r[i] == ROWS - 1) hit = 1;
        else if (m_grid[cur_r[i] + 1][cur_c[i]]) hit = 1;
      end
    end
    return hit;
  endfunction

  // Place the piece, then rebuild the field from its non-full rows, bottom up.
  function automatic lock_exp_t model_lock();
    lock_exp_t  e;
    logic [9:0] keep[$];
    int         k = 0;
    for (int i = 0; i < 4; i++) begin
      if (cur_r[i] < ROWS && cur_c[i] < COLS) begin
        m_grid[cur_r[i]][cur_c[i]] = 1'b1;
        if (cur_r[i] < 2) m_over = 1;
      end
    end
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (m_grid[r] == {COLS{1'b1}}) k++;
      else keep.push_back(m_grid[r]);
    end
    for (int r = ROWS - 1; r >= 0; r--) begin
      m_grid[r] = (keep.size() > 0) ? keep.pop_front() : 10'd0;
    end
    m_total = (m_total + k > 65535) ? 65535 : m_total + k;
`ifdef BOARD_SCORE_EN
    m_score = (m_score + points(k) > 20'hFFFFF) ? 20'hFFFFF : m_score + points(k);
`endif
    e.last  = k;
    e.tot   = m_total;
    e.over  = m_over;
    e.score = m_score;
    e.busy  = ROWS + k + 1;
    return e;
  endfunction

  task automatic set_sq();
    sq_1_col = cur_c[0][3:0]; sq_1_row = cur_r[0][4:0];
    sq_2_col = cur_c[1][3:0]; sq_2_row = cur_r[1][4:0];
    sq_3_col = cur_c[2][3:0]; sq_3_row = cur_r[2][4:0];
    sq_4_col = cur_c[3][3:0]; sq_4_row = cur_r[3][4:0];
  endtask

  task automatic piece(int c0, int r0, int c1, int r1, int c2, int r2, int c3, int r3);
    cur_c[0] = c0; cur_r[0] = r0; cur_c[1] = c1; cur_r[1] = r1;
    cur_c[2] = c2; cur_r[2] = r2; cur_c[3] = c3; cur_r[3] = r3;
  endtask

  // All driver tasks start and end one time unit after a rising edge, DUT idle.
  task automatic do_lock(input bit inject);
    int n = 0;
    bit acc;
    acc = (m_over == 0);
    set_sq();
    lock_en = 1'b1;
    if (acc) lockq.push_back(model_lock());
    @(posedge pclk); #1;
    lock_en = 1'b0;
    check(acc ? "busy_after_lock" : "ignored_lock_busy", busy, acc ? 1 : 0);
    while (busy && n < 200) begin
      lock_en = (inject && n == 3);
      clr     = (inject && n == 3);
      @(posedge pclk); #1;
      n++;
    end
    lock_en = 1'b0;
    clr     = 1'b0;
    check("busy_end", busy, 0);
    check("pending_clear_done", lockq.size(), 0);
    lockq.delete();
  endtask

  task automatic do_clr(input bit with_lock);
    clr = 1'b1;
    if (with_lock) begin
      set_sq();
      lock_en = 1'b1;
    end
    model_reset();
    @(posedge pclk); #1;
    clr     = 1'b0;
    lock_en = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_game_over", game_over, 0);
    check("clr_lines_total", lines_total, 0);
    check("clr_score", score, 0);
  endtask

  task automatic do_read(int r);
    rd_row = r[4:0];
    rd_req = 1'b1;
    rdq.push_back((r < ROWS) ? int'(m_grid[r]) : 0);
    @(posedge pclk); #1;
    rd_req = 1'b0;
  endtask

  task automatic do_coll();
    set_sq();
    coll_req = 1'b1;
    collq.push_back(model_coll());
    @(posedge pclk); #1;
    coll_req = 1'b0;
  endtask

  task automatic rand_sq(int i);
    int p = $urandom_range(0, 31);
    if (p == 0)      begin cur_r[i] = $urandom_range(22, 31); cur_c[i] = $urandom_range(0, 9); end
    else if (p == 1) begin cur_r[i] = $urandom_range(2, 21);  cur_c[i] = $urandom_range(10, 15); end
    else if (p == 2) begin cur_r[i] = $urandom_range(0, 1);   cur_c[i] = $urandom_range(0, 9); end
    else if (p < 8)  begin cur_r[i] = $urandom_range(2, 21);  cur_c[i] = $urandom_range(0, 9); end
    else             begin cur_r[i] = 21 - $urandom_range(0, 3); cur_c[i] = $urandom_range(0, 9); end
  endtask

  always @(posedge pclk) rd_req_d <= rd_req;

  // Monitor: compare every DUT response against the head of its queue.
  initial begin
    int        busy_cnt = 0;
    int        sc_pend = 0;
    int        sc_exp = 0;
    lock_exp_t e;
    forever begin
      @(negedge pclk);
      if (sc_pend != 0) begin
        check("score", score, sc_exp);
        sc_pend = 0;
      end
      if (!rst_n) busy_cnt = 0;
      else if (busy) busy_cnt++;
      else busy_cnt = 0;
      if (coll_req && collq.size() > 0) check("collision", collision, collq.pop_front());
      if (rd_req_d && rdq.size() > 0) check("rd_data", rd_data, rdq.pop_front());
      if (clear_done) begin
        check("clear_done_expected", lockq.size() > 0, 1);
        if (lockq.size() > 0) begin
          e = lockq.pop_front();
          check("lines_last", lines_last, e.last);
          check("lines_total", lines_total, e.tot);
          check("game_over", game_over, e.over);
          check("busy_cycles", busy_cnt, e.busy);
          sc_exp  = e.score;
          sc_pend = 1;
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge pclk);
    #3 rst_n = 1'b1;
    @(posedge pclk); #1;
    // reset state
    check("rst_busy", busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_game_over", game_over, 0);
    check("rst_lines_last", lines_last, 0);
    check("rst_lines_total", lines_total, 0);
    check("rst_score", score, 0);
    check("rst_rd_data", rd_data, 0);
    // empty-board collision: floor and free space
    piece(0, 21, 1, 21, 2, 21, 3, 21); do_coll();
    piece(0, 20, 1, 20, 2, 20, 3, 20); do_coll();
    // O piece at the bottom
    piece(4, 20, 5, 20, 4, 21, 5, 21); do_lock(1'b0);
    do_read(21);
    piece(4, 19, 12, 3, 0, 25, 0, 5); do_coll();
    // complete row 21, row 20 drops into it
    piece(0, 21, 1, 21, 2, 21, 3, 21); do_lock(1'b0);
    piece(6, 21, 7, 21, 8, 21, 9, 21); do_lock(1'b0);
    do_read(21); do_read(20);
    // four-line clear with a vertical I in column 9
    do_clr(1'b0);
    for (int r = 18; r < 22; r++) begin
      piece(0, r, 1, r, 2, r, 3, r); do_lock(1'b0);
      piece(4, r, 5, r, 6, r, 7, r); do_lock(1'b0);
    end
    piece(8, 18, 8, 19, 8, 20, 8, 21); do_lock(1'b0);
    piece(9, 18, 9, 19, 9, 20, 9, 21); do_lock(1'b1);
    for (int r = 17; r < 22; r++) do_read(r);
    // game over from a lock in the hidden rows
    piece(0, 1, 0, 2, 0, 3, 0, 4); do_lock(1'b0);
    piece(5, 21, 6, 21, 7, 21, 8, 21); do_lock(1'b0);
    for (int r = 1; r < 5; r++) do_read(r);
    do_read(21);
    do_clr(1'b0);
    do_read(2); do_read(21); do_read(23);
    // simultaneous clr and lock: clr wins
    piece(3, 21, 4, 21, 5, 21, 6, 21); do_clr(1'b1);
    do_read(21);
    // randomized locks, reads and collision queries
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 4; i++) rand_sq(i);
      if ($urandom_range(0, 11) == 0) do_clr(1'b1);
      else do_lock($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) begin
        cur_r[i] = $urandom_range(0, 31);
        cur_c[i] = $urandom_range(0, 15);
      end
      do_coll();
      do_read($urandom_range(0, 23));
      do_read($urandom_range(17, 21));
      if (m_over != 0 && $urandom_range(0, 1) == 1) do_clr(1'b0);
    end
    // reset asserted while a row is being cleared
    do_clr(1'b0);
    piece(0, 21, 1, 21, 2, 21, 3, 21); do_lock(1'b0);
    piece(4, 21, 5, 21, 6, 21, 7, 21); do_lock(1'b0);
    piece(8, 21, 9, 21, 8, 20, 9, 20); do_lock(1'b0);
    piece(0, 21, 1, 21, 2, 21, 3, 21); do_lock(1'b0);
    piece(4, 21, 5, 21, 6, 21, 7, 21); set_sq();
    lock_en = 1'b1;
    @(posedge pclk); #1;
    lock_en = 1'b0;
    @(posedge pclk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_clear_done", clear_done, 0);
    check("midrst_lines_last", lines_last, 0);
    check("midrst_lines_total", lines_total, 0);
    check("midrst_score", score, 0);
    check("midrst_game_over", game_over, 0);
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge pclk); #1;
    for (int r = 0; r < ROWS; r++) do_read(r);
    piece(2, 21, 3, 21, 2, 20, 3, 20); do_lock(1'b0);
    do_read(21);
    repeat (3) @(posedge pclk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
